// File: rtl/uart_pkg.sv
// Shared types and helpers for the runtime-configurable UART receiver.
package uart_pkg;

  localparam int UART_SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } uart_rx_state_t;

  // 00=5, 01=6, 10=7, 11=8 data bits
  function automatic logic [3:0] data_bits_f(input logic [1:0] cfg_data_bits);
    return 4'd5 + {2'b00, cfg_data_bits};
  endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Valid/ready frame delivery from the receiver to the RX FIFO or register file.
interface uart_rx_cfg_if #(
  parameter int MAX_DATA_BITS = 8
);
  logic                     m_valid;
  logic                     m_ready;
  logic [MAX_DATA_BITS-1:0] m_data;
  logic                     m_parity_err;
  logic                     m_frame_err;

  modport master (
    output m_valid,
    output m_data,
    output m_parity_err,
    output m_frame_err,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_parity_err,
    input  m_frame_err,
    output m_ready
  );
endinterface

// File: rtl/uart_rx_sampler.sv
// Line synchronizer, oversampling bit counter and 3-sample majority voter.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic arst_n,
  input  logic tick,
  input  logic rx,
  input  logic cnt_clr,
  output logic rxs,
  output logic bit_val,
  output logic bit_mid,
  output logic bit_end
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int M  = OVERSAMPLE / 2;

  logic [UART_SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]               cnt;
  logic [1:0]                  smp_q;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) sync_q <= '1;
    else         sync_q <= {sync_q[UART_SYNC_STAGES-2:0], rx};
  end

  assign rxs = sync_q[UART_SYNC_STAGES-1];

  // Explicit wrap keeps non-power-of-two oversample ratios correct
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)                                   cnt <= '0;
    else if (cnt_clr)                              cnt <= '0;
    else if (tick && cnt == CW'(OVERSAMPLE - 1))   cnt <= '0;
    else if (tick)                                 cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      smp_q <= 2'b11;
    end else if (tick) begin
      if (cnt == CW'(M - 1)) smp_q[0] <= rxs;
      if (cnt == CW'(M))     smp_q[1] <= rxs;
    end
  end

  // Third sample is taken live so the vote is ready on the mid strobe itself
  assign bit_val = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs) | (smp_q[1] & rxs);
  assign bit_mid = tick && (cnt == CW'(M + 1));
  assign bit_end = tick && (cnt == CW'(OVERSAMPLE - 1));

endmodule

// File: rtl/uart_rx_cfg.sv
// UART receiver with per-frame latched format: FSM, shift register, error flags
// and the one-entry output holding register.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE    = 16,
  parameter int MAX_DATA_BITS = 8
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic          tick,
  input  logic          rx,
  input  logic [1:0]    cfg_data_bits,
  input  logic          cfg_parity_en,
  input  logic          cfg_parity_odd,
  input  logic          cfg_stop2,
  uart_rx_cfg_if.master m,
  output logic          overrun_error,
  output logic          break_det
);

  uart_rx_state_t           state_q, state_d;
  logic                     rxs, bit_val, bit_mid, bit_end;
  logic                     start, complete, is_break, ferr_now, load;
  logic [1:0]               bits_q;
  logic                     par_en_q, par_odd_q, stop2_q;
  logic [2:0]               bit_idx_q, last_idx;
  logic                     stop_idx_q;
  logic [MAX_DATA_BITS-1:0] data_q;
  logic                     perr_q, ferr_q, pbit_q, stop0_q;

  uart_rx_sampler #(.OVERSAMPLE(OVERSAMPLE)) u_sampler (
    .clk     (clk),
    .arst_n  (arst_n),
    .tick    (tick),
    .rx      (rx),
    .cnt_clr (start),
    .rxs     (rxs),
    .bit_val (bit_val),
    .bit_mid (bit_mid),
    .bit_end (bit_end)
  );

  assign last_idx = 3'(data_bits_f(bits_q) - 4'd1);
  assign ferr_now = ferr_q | ~bit_val;
  // With one stop bit the first stop bit is the one being voted right now
  assign is_break = (data_q == '0) && (!par_en_q || !pbit_q) &&
                    (stop2_q ? !stop0_q : !bit_val);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    complete = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rxs) begin
          state_d = S_START;
          start   = 1'b1;
        end
      end
      S_START: begin
        if (bit_mid && bit_val) state_d = S_IDLE;
        else if (bit_end)       state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end && bit_idx_q == last_idx)
          state_d = par_en_q ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_mid && stop_idx_q == stop2_q) begin
          complete = 1'b1;
          state_d  = is_break ? S_BREAK : S_IDLE;
        end
      end
      S_BREAK: begin
        if (rxs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      bits_q     <= '0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      stop2_q    <= 1'b0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      data_q     <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      pbit_q     <= 1'b0;
      stop0_q    <= 1'b1;
    end else if (start) begin
      bits_q     <= cfg_data_bits;
      par_en_q   <= cfg_parity_en;
      par_odd_q  <= cfg_parity_odd;
      stop2_q    <= cfg_stop2;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      data_q     <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      pbit_q     <= 1'b0;
      stop0_q    <= 1'b1;
    end else begin
      case (state_q)
        S_DATA: begin
          if (bit_mid) data_q[bit_idx_q] <= bit_val;
          if (bit_end) bit_idx_q <= bit_idx_q + 3'd1;
        end
        S_PARITY: begin
          if (bit_mid) begin
            perr_q <= (^data_q) ^ bit_val ^ par_odd_q;
            pbit_q <= bit_val;
          end
        end
        S_STOP: begin
          if (bit_mid) begin
            ferr_q <= ferr_now;
            if (!stop_idx_q) stop0_q <= bit_val;
          end
          if (bit_end) stop_idx_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign load = complete && !is_break && (!m.m_valid || m.m_ready);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      m.m_valid      <= 1'b0;
      m.m_data       <= '0;
      m.m_parity_err <= 1'b0;
      m.m_frame_err  <= 1'b0;
      overrun_error  <= 1'b0;
      break_det      <= 1'b0;
    end else begin
      overrun_error <= complete && !is_break && m.m_valid && !m.m_ready;
      break_det     <= complete && is_break;
      if (load) begin
        m.m_valid      <= 1'b1;
        m.m_data       <= data_q;
        m.m_parity_err <= perr_q;
        m.m_frame_err  <= ferr_now;
      end else if (m.m_valid && m.m_ready) begin
        m.m_valid <= 1'b0;
      end
    end
  end

endmodule
